simon_seq_ctrl: RTL

- Sequence controller for the Simon game; sits directly downstream of the 2-bit colour LFSR on the slow clock.
- Pulses the LFSR enable once per round to draw one new colour and appends it to an internal pattern memory.
- Plays the whole pattern back on one-hot LEDs, then checks the player's button presses against it.
- Reports round count, fail and win to the display/top level.

---
 rtl/simon_seq_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/simon_seq_ctrl.sv
// Simon game sequence controller: grows a colour pattern from the LFSR, plays it back, checks presses.
// Optional per-press input timeout in WAIT_IN when SIMON_TIMEOUT_EN is defined.
module simon_seq_ctrl #(
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned ON_TICKS      = 4,
    parameter int unsigned GAP_TICKS     = 2,
    parameter int unsigned TIMEOUT_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [1:0] i_lfsr_q,
    output logic       o_lfsr_en,
    input  logic       i_btn_valid,
    input  logic [1:0] i_btn_code,
    output logic [3:0] o_led,
    output logic       o_input_phase,
    output logic [5:0] o_round,
    output logic       o_fail,
    output logic       o_win
);
    localparam int unsigned LEN_W   = 6;
    localparam int unsigned MEM_D   = 64;
    localparam int unsigned CNT_M01 = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int unsigned CNT_MAX = (CNT_M01 > TIMEOUT_TICKS) ? CNT_M01 : TIMEOUT_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GROW,
        S_SHOW_ON,
        S_SHOW_GAP,
        S_WAIT_IN,
        S_FAIL,
        S_WIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   r_idx;
    logic [LEN_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_mem [MEM_D];

    logic               r_lfsr_en;
    logic [3:0]         r_led;
    logic               r_input_phase;
    logic               r_fail;
    logic               r_win;

    logic               w_lfsr_en_nxt;
    logic [3:0]         w_led_nxt;
    logic               w_input_phase_nxt;
    logic               w_fail_nxt;
    logic               w_win_nxt;
    logic [1:0]         w_show_col;
    logic               w_last;
    logic               w_hit;

    assign w_last = (r_idx == (r_len - LEN_W'(1)));
    assign w_hit  = (i_btn_code == r_mem[r_idx]);

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_lfsr_en     <= 1'b0;
            r_led         <= '0;
            r_input_phase <= 1'b0;
            r_fail        <= 1'b0;
            r_win         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_lfsr_en     <= w_lfsr_en_nxt;
            r_led         <= w_led_nxt;
            r_input_phase <= w_input_phase_nxt;
            r_fail        <= w_fail_nxt;
            r_win         <= w_win_nxt;
        end
    end

    // Pattern memory captures the LFSR colour before it advances
    always_ff @(posedge clk) begin
        if (r_state == S_GROW) begin
            r_mem[r_len] <= i_lfsr_q;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_len_nxt         = r_len;
        w_idx_nxt         = r_idx;
        w_cnt_nxt         = r_cnt;
        w_lfsr_en_nxt     = 1'b0;
        w_led_nxt         = '0;
        w_input_phase_nxt = 1'b0;
        w_fail_nxt        = 1'b0;
        w_win_nxt         = 1'b0;
        w_show_col        = '0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_GROW;
                    w_len_nxt   = '0;
                end
            end
            S_GROW: begin
                w_len_nxt   = r_len + LEN_W'(1);
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (r_cnt == CNT_W'(ON_TICKS - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHOW_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SHOW_GAP: begin
                if (r_cnt == CNT_W'(GAP_TICKS - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_WAIT_IN;
                    end else begin
                        w_idx_nxt   = r_idx + LEN_W'(1);
                        w_state_nxt = S_SHOW_ON;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_IN: begin
                if (i_btn_valid) begin
                    if (w_hit) begin
                        w_cnt_nxt = '0;
                        if (w_last) begin
                            w_state_nxt = (r_len == LEN_W'(MAX_LEN)) ? S_WIN : S_GROW;
                        end else begin
                            w_idx_nxt = r_idx + LEN_W'(1);
                        end
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_FAIL, S_WIN: begin
                if (i_start) begin
                    w_state_nxt = S_GROW;
                    w_len_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Colour being written this cycle is not yet in memory, so bypass it
        if ((r_state == S_GROW) && (w_idx_nxt == r_len)) begin
            w_show_col = i_lfsr_q;
        end else begin
            w_show_col = r_mem[w_idx_nxt];
        end

        w_lfsr_en_nxt     = (w_state_nxt == S_GROW);
        w_input_phase_nxt = (w_state_nxt == S_WAIT_IN);
        w_fail_nxt        = (w_state_nxt == S_FAIL);
        w_win_nxt         = (w_state_nxt == S_WIN);
        if (w_state_nxt == S_SHOW_ON) begin
            w_led_nxt = 4'b0001 << w_show_col;
        end
    end

    assign o_lfsr_en     = r_lfsr_en;
    assign o_led         = r_led;
    assign o_input_phase = r_input_phase;
    assign o_round       = r_len;
    assign o_fail        = r_fail;
    assign o_win         = r_win;

endmodule
